input_conditioner: RTL and testbench
====================================

# input_conditioner

Multi-channel conditioner for asynchronous inputs such as buttons, external triggers and strap pins. Each channel passes through a parametrised-depth synchronizer, then a run-time programmable glitch filter, and produces a clean level plus one-cycle rise and fall strobes. It sits at the chip-boundary input stage, ahead of the trigger and sampling logic, and generalises the fixed two-flop synchronizer with configurable depth, filtering and edge detection.

## Interface
- WIDTH, 1: number of independent channels.
- SYNC_STAGES, 2: synchronizer flop depth. Legal range is 2..8. Elaboration fails outside this range.
- FILTER_BITS, 4: width of the filter counter and of filter_len.
- RESET_VALUE, 0: WIDTH-bit value loaded into every sync stage and into dataout on reset.

- clk  input  1  single system clock. All state changes on its rising edge.
- reset  input  1  asynchronous, active-high. Clears all state immediately.
- datain  input  WIDTH  asynchronous raw inputs.
- filter_len  input  FILTER_BITS  number of extra consecutive agreeing cycles required. 0 bypasses the filter. Quasi-static, shared by all channels.
- dataout  output  WIDTH  filtered, synchronized level.
- rise  output  WIDTH  one-cycle strobe per channel when dataout goes 0->1.
- fall  output  WIDTH  one-cycle strobe per channel when dataout goes 1->0.

## Operation
- Sync chain: per channel, a shift of SYNC_STAGES flops. sync_q is the last stage.
- Filter: per channel, a counter cnt[FILTER_BITS-1:0]. Each edge:
  - sync_q == dataout: cnt <= 0.
  - sync_q != dataout and cnt >= filter_len: dataout <= sync_q, cnt <= 0. Assert rise or fall according to the new value.
  - Otherwise: cnt <= cnt + 1.
- cnt cannot wrap, because the >= compare fires at or before the maximum value.
- A glitch shorter than filter_len+1 cycles at sync_q resets cnt and never reaches dataout.
- Strobes are registered and high for exactly one cycle. rise and fall of the same channel are never high together.
- Channels are fully independent. Any mix of channels may update and strobe in the same cycle.
- filter_len changes take effect on the next edge, compared against the current cnt.
  - If the new value is below cnt, a pending change commits on the next edge.
- Reset (asynchronous, any time, including mid-count):
  - all sync stages and dataout go to RESET_VALUE;
  - cnt goes to 0;
  - rise and fall go to 0;
  - any pending transition is discarded.
- No strobe is generated by reset assertion or deassertion.
- After reset, if datain differs from RESET_VALUE, a normal transition follows with full latency and a strobe.

## Timing
- Latency is measured from the first edge that samples a stable new datain to the edge where dataout and the strobe update. It is SYNC_STAGES + filter_len + 1 edges.
  - Example: SYNC_STAGES=2, filter_len=0 gives 3 edges.
- Minimum accepted pulse width at sync_q is filter_len+1 cycles. Shorter pulses are fully rejected.
- Outputs are pure flop outputs. No combinational path exists from any input to any output.
- First-stage sampling of datain may go metastable. Only the first stage may be affected. Timing constraints treat datain as asynchronous.

## Structure
- Shared package holds:
  - SYNC_STAGES_MIN = 2;
  - SYNC_STAGES_MAX = 8;
  - an elaboration check function for the legal parameter range.
- Sub-module cond_channel holds one channel's sync chain, filter counter, level register and edge strobes.
  - The top instantiates it WIDTH times in a generate loop.
  - filter_len fans out to every instance.
- No typedefs are needed beyond the package constants.

## Test plan
- Reset, bypass, rising edge. Set RESET_VALUE=0, SYNC_STAGES=2, filter_len=0. Release reset and raise datain[0] before edge k. Required: dataout[0]=1 and rise[0]=1 at edge k+2 (3rd edge). rise[0] is back to 0 one edge later. fall stays 0.
- Glitch rejection. Set filter_len=3 and drive a 3-cycle high pulse at sync_q. Required: dataout, rise and fall are unchanged. Repeat with a 4-cycle pulse. Required: dataout rises 4 cycles after sync_q rises, with a single rise strobe.
- Multi-channel, simultaneous events. Set WIDTH=4, filter_len=1. Drive datain 4'b0000 -> 4'b0101, then later 4'b0101 -> 4'b1010 on the same edge. Required: rise=4'b0101 in one cycle. Later, rise=4'b1010 and fall=4'b0101 together in one cycle.
- Reset mid-count. Set filter_len=7 and hold datain high. Assert reset asynchronously (between edges) 5 cycles after sync_q rises. Required: all outputs 0 immediately and no strobe. After release, dataout rises exactly 2+7+1 edges later.
- filter_len lowered mid-count. Start with filter_len=10 and cnt=6. Change filter_len to 2. Required: dataout commits on the next edge.
- Non-zero RESET_VALUE with SYNC_STAGES=4. Set RESET_VALUE=1. Hold datain=1 through reset release. Required: no strobe. Then drop datain. Required: fall at edge 4+filter_len+1.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
//   Constants and elaboration-time helpers shared by the input conditioner
//   top level and its per-channel sub-module.
//   - SYNC_STAGES_MIN / SYNC_STAGES_MAX : legal synchronizer depth range
//   - sync_stages_legal()               : range check used during elaboration
package input_conditioner_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 8;

  // True when the requested synchronizer depth is inside the legal range.
  function automatic bit sync_stages_legal(input int stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// cond_channel
//   One channel of the input conditioner: a SYNC_STAGES-deep synchronizer,
//   a glitch filter with a run-time programmable length and registered
//   one-cycle rise/fall strobes.
//   Ports:
//     i_clk        : system clock, all state changes on the rising edge
//     i_reset      : asynchronous active-high reset
//     i_datain     : raw asynchronous input
//     i_filter_len : extra consecutive agreeing cycles needed (0 = bypass)
//     o_dataout    : filtered, synchronized level
//     o_rise       : one-cycle strobe when o_dataout goes 0->1
//     o_fall       : one-cycle strobe when o_dataout goes 1->0
module cond_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_BITS = 4,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_datain,
  input  logic [FILTER_BITS-1:0] i_filter_len,
  output logic                   o_dataout,
  output logic                   o_rise,
  output logic                   o_fall
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
  logic [FILTER_BITS-1:0] r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync_q;
  logic w_differ;
  logic w_commit;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync_q != r_level);
  // The >= compare (rather than ==) lets a lowered filter length commit a
  // pending change immediately and guarantees the counter never wraps.
  assign w_commit = w_differ && (r_cnt >= i_filter_len);

  // Synchronizer: only stage 0 samples the asynchronous input.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_datain};
    end
  end

  // Glitch filter, level register and edge strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_level <= RESET_VALUE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_commit &  w_sync_q;
      r_fall <= w_commit & ~w_sync_q;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_level <= w_sync_q;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_dataout = r_level;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   Multi-channel conditioner for asynchronous inputs. Each of the WIDTH
//   channels is synchronized, glitch-filtered and edge-detected
//   independently; the filter length is shared by all channels.
//   Ports:
//     i_clk        : system clock
//     i_reset      : asynchronous active-high reset
//     i_datain     : WIDTH raw asynchronous inputs
//     i_filter_len : shared, quasi-static filter length (0 = bypass)
//     o_dataout    : WIDTH filtered, synchronized levels
//     o_rise       : WIDTH one-cycle rising-edge strobes
//     o_fall       : WIDTH one-cycle falling-edge strobes
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_BITS = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WIDTH-1:0]       i_datain,
  input  logic [FILTER_BITS-1:0] i_filter_len,
  output logic [WIDTH-1:0]       o_dataout,
  output logic [WIDTH-1:0]       o_rise,
  output logic [WIDTH-1:0]       o_fall
);

  // Refuse to elaborate with an out-of-range synchronizer depth.
  generate
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("input_conditioner: SYNC_STAGES=%0d outside %0d..%0d",
             SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      cond_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_BITS (FILTER_BITS),
        .RESET_VALUE (RESET_VALUE[gi])
      ) u_chan (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_datain     (i_datain[gi]),
        .i_filter_len (i_filter_len),
        .o_dataout    (o_dataout[gi]),
        .o_rise       (o_rise[gi]),
        .o_fall       (o_fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Two conditioner instances: A (4 channels, 2 sync stages, reset value 0)
//   and B (1 channel, 4 sync stages, reset value 1). A behavioural model
//   built from sample histories predicts every output on every cycle;
//   directed scenarios add hand-computed literal expectations.
module tb_input_conditioner;

  localparam int SA  = 2;
  localparam int SB  = 4;
  localparam int NCH = 5;  // channels 0..3 -> instance A, channel 4 -> B

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din_a, fl_a, dout_a, rise_a, fall_a;
  logic       din_b;
  logic [3:0] fl_b;
  logic       dout_b, rise_b, fall_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: datain samples and pre-edge sync_q values, one entry per
  // edge since reset (newest at the back), plus expected outputs.
  logic [NCH-1:0] samp[$];
  logic [NCH-1:0] sq_hist[$];
  logic [NCH-1:0] m_lvl, m_rise, m_fall;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(SA), .FILTER_BITS(4), .RESET_VALUE(4'b0000)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_datain(din_a), .i_filter_len(fl_a),
    .o_dataout(dout_a), .o_rise(rise_a), .o_fall(fall_a)
  );

  input_conditioner #(
    .WIDTH(1), .SYNC_STAGES(SB), .FILTER_BITS(4), .RESET_VALUE(1'b1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_datain(din_b), .i_filter_len(fl_b),
    .o_dataout(dout_b), .o_rise(rise_b), .o_fall(fall_b)
  );

  function automatic int stages_of(int c);
    return (c < 4) ? SA : SB;
  endfunction

  function automatic logic rv_of(int c);
    return logic'(c == NCH - 1);
  endfunction

  function automatic int flen_of(int c);
    return (c < 4) ? int'(fl_a) : int'(fl_b);
  endfunction

  // sync_q seen just before the coming edge: the datain sampled S edges
  // ago, or the reset value if fewer than S edges have passed since reset.
  function automatic logic pre_sync(int c);
    int s;
    s = stages_of(c);
    if (samp.size() >= s) return samp[samp.size() - s][c];
    return rv_of(c);
  endfunction

  // Number of immediately preceding edges at which sync_q disagreed with
  // the current level.
  function automatic int streak_of(int c);
    int k;
    k = 0;
    for (int j = sq_hist.size() - 1; j >= 0; j--) begin
      if (sq_hist[j][c] == m_lvl[c]) break;
      k++;
    end
    return k;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    sq_hist.delete();
    m_lvl  = 5'b10000;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] sq_now, nl, nr, nf;
    nl = m_lvl;
    nr = '0;
    nf = '0;
    for (int c = 0; c < NCH; c++) begin
      sq_now[c] = pre_sync(c);
      // A change is accepted once sync_q has disagreed for filter_len+1
      // consecutive edges (this edge included).
      if (sq_now[c] != m_lvl[c] && streak_of(c) >= flen_of(c)) begin
        nl[c] = sq_now[c];
        nr[c] = sq_now[c];
        nf[c] = ~sq_now[c];
      end
    end
    m_lvl  = nl;
    m_rise = nr;
    m_fall = nf;
    sq_hist.push_back(sq_now);
    if (sq_hist.size() > 32) void'(sq_hist.pop_front());
    samp.push_back({din_b, din_a});
    if (samp.size() > 8) void'(samp.pop_front());
  endtask

  task automatic compare_all();
    check("dataout_a", 32'(dout_a), 32'(m_lvl[3:0]));
    check("rise_a",    32'(rise_a), 32'(m_rise[3:0]));
    check("fall_a",    32'(fall_a), 32'(m_fall[3:0]));
    check("dataout_b", 32'(dout_b), 32'(m_lvl[4]));
    check("rise_b",    32'(rise_b), 32'(m_rise[4]));
    check("fall_b",    32'(fall_b), 32'(m_fall[4]));
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset asserted between edges, held for hold edges, released on a
  // falling edge.
  task automatic async_reset_pulse(int hold);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    ticks(hold);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    din_a = 4'b0000;
    fl_a  = 4'd0;
    din_b = 1'b1;
    fl_b  = 4'd0;
    model_reset();
    #1;
    check("rst_dataout_a", 32'(dout_a), 32'(4'b0000));
    check("rst_dataout_b", 32'(dout_b), 32'(1'b1));
    compare_all();
    ticks(2);

    // Bypass filter: rise on the third edge after datain rises.
    rst      = 1'b0;
    din_a[0] = 1'b1;
    ticks(2);
    check("t1_dout_edge2", 32'(dout_a), 32'(4'b0000));
    tick();
    check("t1_dout_edge3", 32'(dout_a), 32'(4'b0001));
    check("t1_rise_edge3", 32'(rise_a), 32'(4'b0001));
    check("t1_fall_edge3", 32'(fall_a), 32'(4'b0000));
    tick();
    check("t1_rise_edge4", 32'(rise_a), 32'(4'b0000));
    check("t1_b_no_strobe", 32'({rise_b, fall_b, dout_b}), 32'(3'b001));

    // Glitch filter length 3: 3-cycle pulse rejected, 4-cycle accepted.
    fl_a     = 4'd3;
    din_a[1] = 1'b1;
    ticks(3);
    din_a[1] = 1'b0;
    ticks(12);
    check("t2_glitch_rejected", 32'(dout_a), 32'(4'b0001));
    din_a[1] = 1'b1;
    ticks(4);
    din_a[1] = 1'b0;
    tick();
    check("t2_dout_before", 32'(dout_a), 32'(4'b0001));
    tick();
    check("t2_dout_accept", 32'(dout_a), 32'(4'b0011));
    check("t2_rise_accept", 32'(rise_a), 32'(4'b0010));
    ticks(12);

    // Simultaneous multi-channel events, filter length 1.
    fl_a  = 4'd1;
    din_a = 4'b0000;
    ticks(8);
    din_a = 4'b0101;
    ticks(3);
    check("t3_rise_early", 32'(rise_a), 32'(4'b0000));
    tick();
    check("t3_rise_0101", 32'(rise_a), 32'(4'b0101));
    check("t3_dout_0101", 32'(dout_a), 32'(4'b0101));
    ticks(4);
    din_a = 4'b1010;
    ticks(4);
    check("t3_rise_1010", 32'(rise_a), 32'(4'b1010));
    check("t3_fall_0101", 32'(fall_a), 32'(4'b0101));
    check("t3_dout_1010", 32'(dout_a), 32'(4'b1010));
    ticks(2);

    // Reset mid-count with filter length 7.
    fl_a  = 4'd7;
    din_a = 4'b1011;
    ticks(7);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t4_rst_dout", 32'(dout_a), 32'(4'b0000));
    check("t4_rst_strobes", 32'({rise_a, fall_a}), 32'(8'h00));
    compare_all();
    ticks(2);
    rst = 1'b0;
    ticks(9);
    check("t4_dout_edge9", 32'(dout_a), 32'(4'b0000));
    tick();
    check("t4_dout_edge10", 32'(dout_a), 32'(4'b1011));
    check("t4_rise_edge10", 32'(rise_a), 32'(4'b1011));

    // Filter length lowered from 10 to 2 while the counter sits at 6.
    fl_a  = 4'd10;
    din_a = 4'b0000;
    ticks(8);
    check("t5_dout_pending", 32'(dout_a), 32'(4'b1011));
    fl_a = 4'd2;
    tick();
    check("t5_dout_commit", 32'(dout_a), 32'(4'b0000));
    check("t5_fall_commit", 32'(fall_a), 32'(4'b1011));

    // Instance B: reset value 1, 4 stages, filter length 2 -> fall at edge 7.
    fl_b  = 4'd2;
    din_b = 1'b0;
    ticks(6);
    check("t6_dout_b_edge6", 32'(dout_b), 32'(1'b1));
    check("t6_fall_b_edge6", 32'(fall_b), 32'(1'b0));
    tick();
    check("t6_dout_b_edge7", 32'(dout_b), 32'(1'b0));
    check("t6_fall_b_edge7", 32'(fall_b), 32'(1'b1));
    tick();
    check("t6_fall_b_edge8", 32'(fall_b), 32'(1'b0));

    // Randomized traffic: toggling inputs, occasional filter-length
    // changes and occasional asynchronous resets.
    for (int i = 0; i < 2500; i++) begin
      if (i % 120 == 0) begin
        fl_a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15))
                                           : 4'($urandom_range(0, 4));
        fl_b = 4'($urandom_range(0, 5));
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) din_a[b] = ~din_a[b];
      end
      if ($urandom_range(0, 4) == 0) din_b = ~din_b;
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse(int'($urandom_range(1, 3)));
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
